timx_apb_master: RTL and testbench

APB3 initiator that turns a simple command/response stream into single APB transfers on the timer's `timx_p*` bus. It is the bus-side counterpart of the timer register file: firmware-side logic, a boot sequencer, or a bench front-end pushes the register programming sequence through it (ARR, CCR1, DIER, CCMR1, EGR, CCER, BDTR, CR1). It generates a spec-correct SETUP/ACCESS phase, waits on `pready`, times out on a hung slave, and returns read data and an error status.

---
 rtl/timx_apb_pkg.sv | 25 ++
 rtl/timx_apb_wait_timer.sv | 41 ++++
 rtl/timx_apb_master.sv | 127 ++++++++++++
 tb/tb_timx_apb_master.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timx_apb_pkg.sv
// Shared types for the timer APB initiator.
// State encoding and the response bundle returned to the command side.
package timx_apb_pkg;

    localparam int TIMX_DATA_W = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SETUP  = ST_SETUP,
        ACCESS = ST_ACCESS,
        RESP   = ST_RESP
    } state_e;

    typedef struct packed {
        logic [TIMX_DATA_W-1:0] rdata;
        logic                   err;
        logic                   timeout;
    } rsp_t;

endpackage

// File: rtl/timx_apb_wait_timer.sv
// Saturating ACCESS wait counter for the timer APB initiator.
// Flags expiry once the count has reached the timeout limit.
module timx_apb_wait_timer
    import timx_apb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Clear on a new transfer, count wait states, never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q >= LIMIT);

endmodule

// File: rtl/timx_apb_master.sv
// APB3 initiator driving single transfers onto the timer bus.
// One command in flight; response held until consumed.
module timx_apb_master
    import timx_apb_pkg::*;
#(
    parameter int          ADDR_W  = 16,
    parameter int          DATA_W  = TIMX_DATA_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              apb_clk,
    input  logic              apb_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              timx_psel,
    output logic              timx_penable,
    output logic              timx_pwrite,
    output logic [ADDR_W-1:0] timx_paddr,
    output logic [DATA_W-1:0] timx_pwdata,
    input  logic [DATA_W-1:0] timx_prdata,
    input  logic              timx_pready,
    input  logic              timx_pslverr
);

    state_e            state_q, state_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    rsp_t              rsp_q, rsp_d;
    logic              cnt_clr;
    logic              cnt_en;
    logic              expired;

    timx_apb_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait (
        .clk    (apb_clk),
        .rst    (apb_rst),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .expired(expired)
    );

    // Reset keeps the command side closed so nothing is taken mid-reset.
    assign cmd_ready    = (state_q == IDLE) && !apb_rst;
    assign timx_psel    = (state_q == SETUP) || (state_q == ACCESS);
    assign timx_penable = (state_q == ACCESS);
    assign timx_pwrite  = pwrite_q;
    assign timx_paddr   = paddr_q;
    assign timx_pwdata  = pwdata_q;
    assign rsp_valid    = (state_q == RESP);
    assign rsp_rdata    = DATA_W'(rsp_q.rdata);
    assign rsp_err      = rsp_q.err;
    assign rsp_timeout  = rsp_q.timeout;

    // Transfer sequencing, bus latching and response capture.
    always_comb begin
        state_d  = state_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rsp_d    = rsp_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    cnt_clr  = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (timx_pready) begin
                    rsp_d.rdata   = pwrite_q ? '0 :
                                    TIMX_DATA_W'(timx_prdata);
                    rsp_d.err     = timx_pslverr;
                    rsp_d.timeout = 1'b0;
                    state_d       = RESP;
                end else if (expired) begin
                    rsp_d.rdata   = '0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                    state_d       = RESP;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, bus and response registers.
    always_ff @(posedge apb_clk) begin
        if (apb_rst) begin
            state_q  <= IDLE;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rsp_q    <= '0;
        end else begin
            state_q  <= state_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rsp_q    <= rsp_d;
        end
    end

endmodule

// File: tb/tb_timx_apb_master.sv
// Bench for the timer APB initiator.
// Timeline model of each transfer checked every cycle.
module tb_timx_apb_master;

    localparam int TMO = 4;

    logic        apb_clk = 1'b0;
    logic        apb_rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        timx_psel;
    logic        timx_penable;
    logic        timx_pwrite;
    logic [15:0] timx_paddr;
    logic [31:0] timx_pwdata;
    logic [31:0] timx_prdata = '0;
    logic        timx_pready = 1'b0;
    logic        timx_pslverr = 1'b0;

    timx_apb_master #(
        .ADDR_W (16),
        .DATA_W (32),
        .TIMEOUT(TMO)
    ) dut (
        .apb_clk     (apb_clk),
        .apb_rst     (apb_rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .timx_psel   (timx_psel),
        .timx_penable(timx_penable),
        .timx_pwrite (timx_pwrite),
        .timx_paddr  (timx_paddr),
        .timx_pwdata (timx_pwdata),
        .timx_prdata (timx_prdata),
        .timx_pready (timx_pready),
        .timx_pslverr(timx_pslverr)
    );

    always #5 apb_clk = ~apb_clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Expected outputs for the current cycle.
    logic        exp_cmd_ready, exp_psel, exp_pen, exp_rv, exp_rc;
    logic        exp_pwrite, exp_err, exp_to;
    logic [15:0] exp_paddr;
    logic [31:0] exp_pwdata, exp_rdata;

    // Last accepted command as seen by the bus.
    logic        m_pwrite = 1'b0;
    logic [15:0] m_paddr = '0;
    logic [31:0] m_pwdata = '0;

    // Observations used by the literal checks.
    int          acc_cyc = 0, acc_len = 0;
    int          lat_last = 0, len_last = 0;
    logic [31:0] rd_last = '0;
    logic        err_last = 1'b0, to_last = 1'b0, prev_rv = 1'b0;
    logic [15:0] acc_q[$];

    logic [15:0] seq_a [8] = '{16'h002C, 16'h0034, 16'h000C, 16'h0018,
                               16'h0014, 16'h0020, 16'h0044, 16'h0000};
    logic [31:0] seq_d [8] = '{32'h3E7, 32'h1F4, 32'h2, 32'h68,
                               32'h1, 32'h1, 32'h8C00, 32'hA1};

    always @(posedge apb_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge apb_clk);
            if (chk_en) begin
                chk("cmd_ready", 64'(cmd_ready), 64'(exp_cmd_ready));
                chk("psel", 64'(timx_psel), 64'(exp_psel));
                chk("penable", 64'(timx_penable), 64'(exp_pen));
                chk("pwrite", 64'(timx_pwrite), 64'(exp_pwrite));
                chk("paddr", 64'(timx_paddr), 64'(exp_paddr));
                chk("pwdata", 64'(timx_pwdata), 64'(exp_pwdata));
                chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
                if (exp_rc) begin
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
                    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
                    chk("rsp_timeout", 64'(rsp_timeout), 64'(exp_to));
                end
                if (cmd_valid && cmd_ready) begin
                    acc_cyc = cyc;
                    acc_len = 0;
                    acc_q.push_back(cmd_addr);
                end
                if (timx_psel && timx_penable) acc_len++;
                if (rsp_valid && !prev_rv) begin
                    lat_last = cyc - acc_cyc;
                    len_last = acc_len;
                    rd_last  = rsp_rdata;
                    err_last = rsp_err;
                    to_last  = rsp_timeout;
                end
                prev_rv = rsp_valid;
            end
        end
    end

    task automatic tick();
        @(posedge apb_clk);
        #1;
    endtask

    task automatic exp_set(input logic cr, input logic ps, input logic pe,
                           input logic rv, input logic rc);
        exp_cmd_ready = cr;
        exp_psel      = ps;
        exp_pen       = pe;
        exp_rv        = rv;
        exp_rc        = rc;
        exp_pwrite    = m_pwrite;
        exp_paddr     = m_paddr;
        exp_pwdata    = m_pwdata;
    endtask

    task automatic rand_bus();
        timx_pready  = 1'($urandom);
        timx_pslverr = 1'($urandom);
        timx_prdata  = $urandom;
    endtask

    task automatic junk();
        cmd_valid = 1'($urandom);
        cmd_write = 1'($urandom);
        cmd_addr  = 16'($urandom);
        cmd_wdata = $urandom;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            apb_rst = 1'b1;
            junk();
            rand_bus();
            m_pwrite = 1'b0;
            m_paddr = '0;
            m_pwdata = '0;
            exp_rdata = '0;
            exp_err = 1'b0;
            exp_to = 1'b0;
            exp_set(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            chk_en = 1'b1;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            apb_rst = 1'b0;
            junk();
            cmd_valid = 1'b0;
            rand_bus();
            rsp_ready = 1'($urandom);
            exp_set(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // One complete transfer from an idle bus.
    task automatic xfer(input logic w, input logic [15:0] a,
                        input logic [31:0] d, input logic [31:0] rd,
                        input int nwait, input logic serr, input int rdly);
        bit to;
        int len;
        to  = (nwait > TMO);
        len = to ? TMO + 1 : nwait + 1;
        tick();
        apb_rst = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr = a;
        cmd_wdata = d;
        rand_bus();
        rsp_ready = 1'($urandom);
        exp_set(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        m_pwrite = w;
        m_paddr = a;
        m_pwdata = d;
        tick();
        junk();
        rand_bus();
        exp_set(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < len; k++) begin
            tick();
            junk();
            timx_pready  = !to && (k == nwait);
            timx_prdata  = (k == nwait) ? rd : $urandom;
            timx_pslverr = (k == len - 1) ? serr : 1'($urandom);
            exp_set(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        exp_rdata = (to || w) ? 32'h0 : rd;
        exp_err   = to || serr;
        exp_to    = to;
        for (int k = 0; k <= rdly; k++) begin
            tick();
            junk();
            rand_bus();
            rsp_ready = (k == rdly);
            exp_set(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        end
    endtask

    task automatic reset_mid();
        tick();
        apb_rst = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr = 16'h0034;
        cmd_wdata = 32'h0BAD_F00D;
        rand_bus();
        exp_set(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        m_pwrite = 1'b0;
        m_paddr = 16'h0034;
        m_pwdata = 32'h0BAD_F00D;
        tick();
        junk();
        exp_set(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            junk();
            timx_pready = 1'b0;
            apb_rst = (k == 2);
            exp_set(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        do_reset(1);
    endtask

    initial begin
        do_reset(2);
        idle_cycles(2);

        xfer(1'b1, 16'h002C, 32'h8, $urandom, 0, 1'b0, 0);
        idle_cycles(1);
        chk("zw_latency", 64'(lat_last), 64'd3);
        chk("zw_access_len", 64'(len_last), 64'd1);
        chk("zw_rdata", 64'(rd_last), 64'd0);
        chk("zw_err", 64'(err_last), 64'd0);

        xfer(1'b0, 16'h0034, $urandom, 32'h7, 3, 1'b0, 0);
        idle_cycles(1);
        chk("rw_access_len", 64'(len_last), 64'd4);
        chk("rw_rdata", 64'(rd_last), 64'h7);

        xfer(1'b1, 16'h0044, 32'h8C00, 32'h0, 0, 1'b1, 0);
        idle_cycles(1);
        chk("se_err", 64'(err_last), 64'd1);
        chk("se_timeout", 64'(to_last), 64'd0);

        xfer(1'b0, 16'h0010, 32'h0, 32'h55, 100, 1'b0, 1);
        idle_cycles(1);
        chk("to_access_len", 64'(len_last), 64'd5);
        chk("to_latency", 64'(lat_last), 64'd7);
        chk("to_err", 64'(err_last), 64'd1);
        chk("to_timeout", 64'(to_last), 64'd1);
        chk("to_rdata", 64'(rd_last), 64'd0);

        xfer(1'b0, 16'h0010, 32'h0, 32'h1234, TMO, 1'b0, 0);
        idle_cycles(1);
        chk("bnd_access_len", 64'(len_last), 64'd5);
        chk("bnd_timeout", 64'(to_last), 64'd0);
        chk("bnd_rdata", 64'(rd_last), 64'h1234);

        acc_q.delete();
        for (int i = 0; i < 8; i++) begin
            xfer(1'b1, seq_a[i], seq_d[i], 32'h0,
                 $urandom_range(0, 2), 1'b0, (i == 2) ? 5 : 0);
        end
        idle_cycles(1);
        chk("seq_count", 64'(acc_q.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < acc_q.size()) chk("seq_addr", 64'(acc_q[i]), 64'(seq_a[i]));
        end

        reset_mid();
        xfer(1'b0, 16'h000C, 32'h0, 32'hBEEF, 1, 1'b0, 0);
        idle_cycles(1);
        chk("post_rst_latency", 64'(lat_last), 64'd4);
        chk("post_rst_rdata", 64'(rd_last), 64'hBEEF);

        for (int i = 0; i < 40; i++) begin
            xfer(1'($urandom), 16'($urandom) & 16'hFFFC, $urandom, $urandom,
                 $urandom_range(0, 6), ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 3));
            idle_cycles($urandom_range(0, 2));
        end
        idle_cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
